serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl_pkg.sv | 21 ++
 rtl/serial_add_ctrl_if.sv | 38 +++
 rtl/FullAdder.sv | 23 ++
 rtl/serial_add_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl_pkg
// Description : Shared constants for the bit-serial add/subtract controller:
//               FSM state encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_ctrl_pkg;

  // Default operand/result width in bits (legal range 2..64).
  localparam int DEFAULT_WIDTH = 32;

  // Controller states. Encoding is fixed so it can be observed in the field.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl_if
// Description : Request/response bundle for the serial adder controller.
//   Requester -> controller : start, sub, a[WIDTH], b[WIDTH]
//   Controller -> requester : busy, done, result[WIDTH], cout, ovf, zero
//   master modport = requester side, slave modport = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf, zero
  );

endinterface
`default_nettype wire

// File: rtl/FullAdder.sv
`default_nettype none
// ============================================================================
// Module      : FullAdder
// Description : Single-bit full adder.
//   i_a, i_b  : operand bits
//   i_cin     : carry in
//   o_sum     : sum bit
//   o_cout    : carry out
// Revision    : 1.0 - initial release
// ============================================================================
module FullAdder (
  input  wire logic i_a,
  input  wire logic i_b,
  input  wire logic i_cin,
  output logic      o_sum,
  output logic      o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder/subtractor. One operand bit per clock, LSB
//               first, through a single full adder. Subtraction is a + ~b + 1.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_add_ctrl_if.slave (start/sub/a/b in; busy/done/result/
//          cout/ovf/zero out)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic        clk,
  input  wire logic        rst,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q,  carry_d;
  logic             cmsb_q,   cmsb_d;   // carry into the MSB, for overflow
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;
  logic             zero_q,   zero_d;
  logic             done_q,   done_d;

  logic             w_fa_sum;
  logic             w_fa_cout;

  FullAdder u_fa (
    .i_a    (a_q[0]),
    .i_b    (b_q[0]),
    .i_cin  (carry_q),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b ^ {WIDTH{bus.sub}};
          carry_d  = bus.sub;               // the "+1" of two's complement
          cnt_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          zero_d   = 1'b1;                  // tracks the cleared result
          state_d  = RUN;
        end
      end

      RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        result_d = {w_fa_sum, result_q[WIDTH-1:1]};
        carry_d  = w_fa_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q is the carry into the MSB on this last bit
          cmsb_d  = carry_q;
          state_d = DONE;
        end
      end

      DONE: begin
        // Flags are registered from the settled result/carry, then the
        // completion pulse is presented together with them.
        cout_d  = carry_q;
        ovf_d   = cmsb_q ^ carry_q;
        zero_d  = (result_q == '0);
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cmsb_q   <= cmsb_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;

endmodule
`default_nettype wire
